regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: requester 0 is the ALU writeback and requester 1 is the memory/load writeback.
- Keeps a pending-write scoreboard so the decode stage can stall on operands that are still in flight.
- Sits between the execute/memory stages and the register file write port. The outputs drive the register file's write_en/write_addr/write_data inputs directly.

---
 rtl/proc_pkg.sv | 20 ++
 rtl/regfile_wb_scoreboard.sv | 53 +++++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor constants and writeback request types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package proc_pkg;

  localparam int PROC_DATA_WIDTH        = 16;
  localparam int PROC_REGFILE_LOG2_DEEP = 5;
  localparam int NUM_REGISTERS          = 32;

  // Requester indices; also the encoding of the round-robin last-grant bit.
  localparam logic WB_REQ_ALU = 1'b0;
  localparam logic WB_REQ_MEM = 1'b1;

  typedef struct packed {
    logic                              valid;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] addr;
    logic [PROC_DATA_WIDTH-1:0]        data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared on writeback.
// Latency: set/clear take effect the cycle after; busy lookup is combinational.
// Backpressure: none; decode stalls on busy_o.
// Ports: set_i/set_addr_i mark a destination pending; clr_i/clr_addr_i are the
// register-file write this cycle; rd_addrK_i/busyK_o are the operand lookups.
module wb_scoreboard
  import proc_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              set_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] set_addr_i,
  input  logic                              clr_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] clr_addr_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] rd_addr1_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] rd_addr2_i,
  output logic                              busy1_o,
  output logic                              busy2_o
);

  logic [NUM_REGISTERS-1:0] pending_q;
  logic [NUM_REGISTERS-1:0] pending_d;

  // Clear first, then set: a same-cycle set belongs to a younger producer
  // and must survive the older producer's writeback.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) begin
      pending_d[clr_addr_i] = 1'b0;
    end
    if (set_i && (set_addr_i != '0)) begin
      pending_d[set_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A write landing this cycle is bypassed by the register file, so the
  // operand is already readable and need not stall.
  always_comb begin
    busy1_o = pending_q[rd_addr1_i] && !(clr_i && (clr_addr_i == rd_addr1_i))
              && (rd_addr1_i != '0);
    busy2_o = pending_q[rd_addr2_i] && !(clr_i && (clr_addr_i == rd_addr2_i))
              && (rd_addr2_i != '0);
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and MEM writeback.
// Latency: grant is combinational; the granted write appears on rf_* one cycle later.
// Backpressure: the losing requester sees ready low and must hold its request.
// Ports: req0_* ALU writeback, req1_* MEM writeback (valid/ready); sb_set_* marks
// an issued destination pending; rd_addrK_i/rd_busyK_o operand stall lookup;
// rf_* drive the register file write port; conflict_cnt_o counts stalled cycles.
module regfile_wb_arbiter
  import proc_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              req0_valid_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] req0_addr_i,
  input  logic [PROC_DATA_WIDTH-1:0]        req0_data_i,
  output logic                              req0_ready_o,
  input  logic                              req1_valid_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] req1_addr_i,
  input  logic [PROC_DATA_WIDTH-1:0]        req1_data_i,
  output logic                              req1_ready_o,
  input  logic                              sb_set_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] sb_set_addr_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] rd_addr1_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] rd_addr2_i,
  output logic                              rd_busy1_o,
  output logic                              rd_busy2_o,
  output logic                              rf_we_o,
  output logic [PROC_REGFILE_LOG2_DEEP-1:0] rf_waddr_o,
  output logic [PROC_DATA_WIDTH-1:0]        rf_wdata_o,
  output logic [15:0]                       conflict_cnt_o
);

  wb_req_t req0;
  wb_req_t req1;
  wb_req_t gnt_req;
  logic    gnt_vld;
  logic    gnt_idx;
  logic    waiting;

  logic                              last_grant_q, last_grant_d;
  logic                              rf_we_q, rf_we_d;
  logic [PROC_REGFILE_LOG2_DEEP-1:0] rf_waddr_q, rf_waddr_d;
  logic [PROC_DATA_WIDTH-1:0]        rf_wdata_q, rf_wdata_d;
  logic [15:0]                       conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    req0 = '{valid: req0_valid_i, addr: req0_addr_i, data: req0_data_i};
    req1 = '{valid: req1_valid_i, addr: req1_addr_i, data: req1_data_i};

    gnt_vld = req0.valid || req1.valid;
    gnt_idx = last_grant_q;
    if (req0.valid && req1.valid) begin
      gnt_idx = ~last_grant_q;
    end else if (req0.valid) begin
      gnt_idx = WB_REQ_ALU;
    end else if (req1.valid) begin
      gnt_idx = WB_REQ_MEM;
    end
    gnt_req = (gnt_idx == WB_REQ_MEM) ? req1 : req0;

    req0_ready_o = gnt_vld && (gnt_idx == WB_REQ_ALU);
    req1_ready_o = gnt_vld && (gnt_idx == WB_REQ_MEM);
    waiting      = (req0.valid && !req0_ready_o) || (req1.valid && !req1_ready_o);

    // Register 0 is hardwired: accept the transfer but suppress the write.
    last_grant_d = gnt_vld ? gnt_idx : last_grant_q;
    rf_we_d      = gnt_vld && (gnt_req.addr != '0);
    rf_waddr_d   = gnt_vld ? gnt_req.addr : rf_waddr_q;
    rf_wdata_d   = gnt_vld ? gnt_req.data : rf_wdata_q;

    conflict_cnt_d = conflict_cnt_q;
    if (waiting && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_grant_q   <= WB_REQ_MEM;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign rf_we_o        = rf_we_q;
  assign rf_waddr_o     = rf_waddr_q;
  assign rf_wdata_o     = rf_wdata_q;
  assign conflict_cnt_o = conflict_cnt_q;

  wb_scoreboard u_scoreboard (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .set_i      (sb_set_i),
    .set_addr_i (sb_set_addr_i),
    .clr_i      (rf_we_q),
    .clr_addr_i (rf_waddr_q),
    .rd_addr1_i (rd_addr1_i),
    .rd_addr2_i (rd_addr2_i),
    .busy1_o    (rd_busy1_o),
    .busy2_o    (rd_busy2_o)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import proc_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req0_valid_i, req1_valid_i;
  logic [4:0]  req0_addr_i, req1_addr_i;
  logic [15:0] req0_data_i, req1_data_i;
  logic        req0_ready_o, req1_ready_o;
  logic        sb_set_i;
  logic [4:0]  sb_set_addr_i, rd_addr1_i, rd_addr2_i;
  logic        rd_busy1_o, rd_busy2_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [15:0] rf_wdata_o;
  logic [15:0] conflict_cnt_o;

  always #5 clk_i = ~clk_i;

  regfile_wb_arbiter dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req0_valid_i(req0_valid_i), .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
    .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
    .req1_ready_o(req1_ready_o),
    .sb_set_i(sb_set_i), .sb_set_addr_i(sb_set_addr_i),
    .rd_addr1_i(rd_addr1_i), .rd_addr2_i(rd_addr2_i),
    .rd_busy1_o(rd_busy1_o), .rd_busy2_o(rd_busy2_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .conflict_cnt_o(conflict_cnt_o)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [15:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Drive point: just after the rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Every register-file write must match the oldest expected write.
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (rst_n_i === 1'b1 && rf_we_o === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(rf_waddr_o), 32'(e.addr));
        chk("wr_data", 32'(rf_wdata_o), 32'(e.data));
      end
    end
  end

  initial begin
    logic [1:0] gseq;
    gseq = 2'b00;
    rst_n_i = 1'b0;
    req0_valid_i = 0; req0_addr_i = 0; req0_data_i = 0;
    req1_valid_i = 0; req1_addr_i = 0; req1_data_i = 0;
    sb_set_i = 0; sb_set_addr_i = 0; rd_addr1_i = 0; rd_addr2_i = 0;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_we", 32'(rf_we_o), 32'd0);
    chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
    chk("rst_wdata", 32'(rf_wdata_o), 32'd0);
    chk("rst_conflict", 32'(conflict_cnt_o), 32'd0);
    cyc();
    rst_n_i = 1'b1;

    // Contention: both valid for 4 cycles, grants 0,1,0,1
    req0_valid_i = 1; req0_addr_i = 5'd3; req0_data_i = 16'hA003;
    req1_valid_i = 1; req1_addr_i = 5'd4; req1_data_i = 16'hB004;
    for (int i = 0; i < 4; i++) begin
      gseq = 2'(i % 2);
      @(negedge clk_i);
      chk("rr_ready0", 32'(req0_ready_o), 32'(gseq == 2'd0));
      chk("rr_ready1", 32'(req1_ready_o), 32'(gseq == 2'd1));
      if (gseq == 2'd0) push(5'd3, 16'hA003);
      else              push(5'd4, 16'hB004);
      cyc();
    end
    req0_valid_i = 0; req1_valid_i = 0;
    @(negedge clk_i);
    chk("conflict_4", 32'(conflict_cnt_o), 32'd4);

    // Single ALU request, one-cycle latency
    cyc();
    req0_valid_i = 1; req0_addr_i = 5'd5; req0_data_i = 16'h1234;
    @(negedge clk_i);
    chk("single_ready0", 32'(req0_ready_o), 32'd1);
    chk("single_ready1", 32'(req1_ready_o), 32'd0);
    push(5'd5, 16'h1234);
    cyc();
    req0_valid_i = 0;
    @(negedge clk_i);
    chk("single_we", 32'(rf_we_o), 32'd1);
    chk("single_waddr", 32'(rf_waddr_o), 32'd5);
    chk("single_wdata", 32'(rf_wdata_o), 32'h1234);

    // Register 0: accepted, never written, never pending
    cyc();
    req0_valid_i = 1; req0_addr_i = 5'd0; req0_data_i = 16'hFFFF;
    sb_set_i = 1; sb_set_addr_i = 5'd0; rd_addr1_i = 5'd0; rd_addr2_i = 5'd0;
    @(negedge clk_i);
    chk("r0_ready0", 32'(req0_ready_o), 32'd1);
    chk("r0_busy1", 32'(rd_busy1_o), 32'd0);
    cyc();
    req0_valid_i = 0; sb_set_i = 0;
    req1_valid_i = 1; req1_addr_i = 5'd0; req1_data_i = 16'h00AA;
    @(negedge clk_i);
    chk("r0_we", 32'(rf_we_o), 32'd0);
    chk("r0_waddr", 32'(rf_waddr_o), 32'd0);
    chk("r0_wdata", 32'(rf_wdata_o), 32'hFFFF);
    chk("r0_ready1", 32'(req1_ready_o), 32'd1);
    chk("r0_busy2", 32'(rd_busy2_o), 32'd0);
    // last grant is now MEM (from the register-0 write), so ALU wins next
    cyc();
    req0_valid_i = 1; req0_addr_i = 5'd3; req0_data_i = 16'h0303;
    req1_valid_i = 1; req1_addr_i = 5'd4; req1_data_i = 16'h0404;
    @(negedge clk_i);
    chk("r0b_we", 32'(rf_we_o), 32'd0);
    chk("r0b_wdata", 32'(rf_wdata_o), 32'h00AA);
    chk("rr_adv_ready0", 32'(req0_ready_o), 32'd1);
    chk("rr_adv_ready1", 32'(req1_ready_o), 32'd0);
    push(5'd3, 16'h0303);
    cyc();
    req0_valid_i = 0; req1_valid_i = 0;
    @(negedge clk_i);
    chk("conflict_5", 32'(conflict_cnt_o), 32'd5);

    // Scoreboard set and writeback clear on register 7
    cyc();
    sb_set_i = 1; sb_set_addr_i = 5'd7; rd_addr1_i = 5'd7;
    @(negedge clk_i);
    chk("sb7_pre", 32'(rd_busy1_o), 32'd0);
    cyc();
    sb_set_i = 0;
    @(negedge clk_i);
    chk("sb7_busy", 32'(rd_busy1_o), 32'd1);
    cyc();
    req1_valid_i = 1; req1_addr_i = 5'd7; req1_data_i = 16'h7777;
    @(negedge clk_i);
    chk("sb7_ready1", 32'(req1_ready_o), 32'd1);
    chk("sb7_busy_req", 32'(rd_busy1_o), 32'd1);
    push(5'd7, 16'h7777);
    cyc();
    req1_valid_i = 0;
    @(negedge clk_i);
    chk("sb7_we", 32'(rf_we_o), 32'd1);
    chk("sb7_bypass", 32'(rd_busy1_o), 32'd0);
    cyc();
    @(negedge clk_i);
    chk("sb7_cleared", 32'(rd_busy1_o), 32'd0);

    // Set and clear of register 9 in the same cycle: set wins
    cyc();
    sb_set_i = 1; sb_set_addr_i = 5'd9; rd_addr1_i = 5'd9;
    cyc();
    sb_set_i = 0;
    req0_valid_i = 1; req0_addr_i = 5'd9; req0_data_i = 16'h0909;
    @(negedge clk_i);
    chk("sb9_busy", 32'(rd_busy1_o), 32'd1);
    push(5'd9, 16'h0909);
    cyc();
    req0_valid_i = 0; sb_set_i = 1; sb_set_addr_i = 5'd9;
    @(negedge clk_i);
    chk("sb9_we", 32'(rf_we_o), 32'd1);
    chk("sb9_bypass", 32'(rd_busy1_o), 32'd0);
    cyc();
    sb_set_i = 0;
    @(negedge clk_i);
    chk("sb9_set_wins", 32'(rd_busy1_o), 32'd1);
    chk("sb9_we_idle", 32'(rf_we_o), 32'd0);

    // Reset while a transfer is staged
    cyc();
    req0_valid_i = 1; req0_addr_i = 5'd11; req0_data_i = 16'h1111;
    @(negedge clk_i);
    chk("rst_t_ready0", 32'(req0_ready_o), 32'd1);
    push(5'd11, 16'h1111);
    cyc();
    req0_addr_i = 5'd12; req0_data_i = 16'h2222;
    @(negedge clk_i);
    chk("rst_t_ready0b", 32'(req0_ready_o), 32'd1);
    chk("rst_t_we_before", 32'(rf_we_o), 32'd1);
    #1 rst_n_i = 1'b0;
    #1;
    chk("rst_async_we", 32'(rf_we_o), 32'd0);
    chk("rst_async_waddr", 32'(rf_waddr_o), 32'd0);
    chk("rst_async_wdata", 32'(rf_wdata_o), 32'd0);
    chk("rst_async_conflict", 32'(conflict_cnt_o), 32'd0);
    chk("rst_async_busy9", 32'(rd_busy1_o), 32'd0);
    req0_valid_i = 0;
    cyc();
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("post_rst_we", 32'(rf_we_o), 32'd0);
      chk("post_rst_busy9", 32'(rd_busy1_o), 32'd0);
    end

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
